// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter
//   Controller for the eight-digit seven-segment display. It holds the shared
//   32-bit display word, arbitrates round-robin between two writers, and scans
//   the digits with a programmable per-digit dwell.
//
// Parameters
//   PRESCALE    clocks each digit is held before advancing (>= 1)
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   req0/data0  write request + data, requester 0 (CPU)
//   gnt0        one-cycle grant, requester 0
//   req1/data1  write request + data, requester 1 (debug)
//   gnt1        one-cycle grant, requester 1
//   disp_word   current display word
//   digit_idx   digit currently scanned
//   digit       nibble of disp_word selected by digit_idx
//   sel         one-hot digit select
//   frame_done  one-cycle pulse when the digit 7 dwell completes
//
// Build option
//   SEG_LZB_EN  leading-zero blanking: digits above the most significant
//               non-zero nibble get sel = 0 (digit 0 is always shown).
module seg_scan_arbiter #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] data0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        gnt1,
  output logic [31:0] disp_word,
  output logic [2:0]  digit_idx,
  output logic [3:0]  digit,
  output logic [7:0]  sel,
  output logic        frame_done
);

  localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);

  logic [31:0]       disp_word_reg;
  logic [2:0]        digit_idx_reg;
  logic [PCNT_W-1:0] pcnt_reg;
  logic              lg_reg;
  logic              gnt0_reg;
  logic              gnt1_reg;
  logic              frame_done_reg;

  logic elig0, elig1;
  logic win0, win1;
  logic [7:0] sel_onehot;

  // A requester still holding req during its own grant cycle is not
  // eligible, so one request never produces two back-to-back grants.
  assign elig0 = req0 & ~gnt0_reg;
  assign elig1 = req1 & ~gnt1_reg;

  // On a tie the requester that did not win last time gets the grant.
  assign win0 = elig0 & (~elig1 | lg_reg);
  assign win1 = elig1 & (~elig0 | ~lg_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_word_reg  <= '0;
      digit_idx_reg  <= '0;
      pcnt_reg       <= '0;
      lg_reg         <= 1'b1;
      gnt0_reg       <= 1'b0;
      gnt1_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      gnt0_reg       <= win0;
      gnt1_reg       <= win1;
      frame_done_reg <= 1'b0;
      if (win0 | win1) begin
        // A write restarts the scan at digit 0 and never pulses frame_done.
        disp_word_reg <= win0 ? data0 : data1;
        lg_reg        <= win1;
        digit_idx_reg <= '0;
        pcnt_reg      <= '0;
      end else if (pcnt_reg == PCNT_MAX) begin
        pcnt_reg      <= '0;
        digit_idx_reg <= digit_idx_reg + 3'd1;
        if (digit_idx_reg == 3'd7) begin
          frame_done_reg <= 1'b1;
        end
      end else begin
        pcnt_reg <= pcnt_reg + PCNT_W'(1);
      end
    end
  end

  assign gnt0       = gnt0_reg;
  assign gnt1       = gnt1_reg;
  assign disp_word  = disp_word_reg;
  assign digit_idx  = digit_idx_reg;
  assign frame_done = frame_done_reg;

  assign digit      = disp_word_reg[{digit_idx_reg, 2'b00} +: 4];
  assign sel_onehot = 8'h01 << digit_idx_reg;

`ifdef SEG_LZB_EN
  // digit_live[k] is set when some nibble at position k or above is non-zero.
  logic [7:0] digit_live;

  assign digit_live[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_live
      assign digit_live[gi] = |disp_word_reg[31:4*gi];
    end
  endgenerate

  assign sel = sel_onehot & digit_live;
`else
  assign sel = sel_onehot;
`endif

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// tb_seg_scan_arbiter
//   Directed bench for seg_scan_arbiter (PRESCALE = 16). Expected grants are
//   queued when requests are issued; a monitor pops and compares whenever a
//   grant appears. Scan, frame and reset behaviour are checked inline.
module tb_seg_scan_arbiter;

  localparam int P = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [31:0] data0 = '0;
  logic [31:0] data1 = '0;
  logic        gnt0, gnt1, frame_done;
  logic [31:0] disp_word;
  logic [2:0]  digit_idx;
  logic [3:0]  digit;
  logic [7:0]  sel;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        who;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];

  seg_scan_arbiter #(.PRESCALE(P)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .data1(data1), .gnt1(gnt1),
    .disp_word(disp_word), .digit_idx(digit_idx), .digit(digit),
    .sel(sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] exp_sel(input logic [31:0] w, input int idx);
    logic [7:0] s;
    s = 8'h01 << idx;
`ifdef SEG_LZB_EN
    if (idx > 0 && (w >> (4 * idx)) == 32'd0) s = 8'h00;
`endif
    return s;
  endfunction

  task automatic push_exp(input logic who, input logic [31:0] word);
    exp_t e;
    e.who  = who;
    e.word = word;
    exp_q.push_back(e);
  endtask

  // Grant monitor / scoreboard
  initial begin
    exp_t e;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        chk("gnt_overlap", 32'(gnt0 & gnt1), 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant: got gnt0=%b gnt1=%b expected none", gnt0, gnt1);
        end else begin
          e = exp_q.pop_front();
          w = e.word;
          $display("grant: requester %0d word=%h", gnt1 ? 1 : 0, disp_word);
          chk("gnt_who",   32'(gnt1), 32'(e.who));
          chk("gnt_word",  disp_word, w);
          chk("gnt_digit", 32'(digit), 32'(w[3:0]));
          chk("gnt_idx",   32'(digit_idx), 32'd0);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_disp_word",  disp_word, 32'd0);
    chk("rst_digit_idx",  32'(digit_idx), 32'd0);
    chk("rst_sel",        32'(sel), 32'h01);
    chk("rst_digit",      32'(digit), 32'd0);
    chk("rst_gnt0",       32'(gnt0), 32'd0);
    chk("rst_gnt1",       32'(gnt1), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);

    // Idle scan: two full frames
    for (int k = 1; k <= 2 * 8 * P; k++) begin
      @(negedge clk);
      chk("scan_sel", 32'(sel), 32'(exp_sel(32'd0, (k / P) % 8)));
      chk("scan_frame_done", 32'(frame_done), 32'((k % (8 * P)) == 0));
      if (k % P == 0) chk("scan_digit", 32'(digit), 32'd0);
    end

    // Single CPU write
    req0 = 1'b1;
    data0 = 32'h89ABCDEF;
    push_exp(1'b0, 32'h89ABCDEF);
    @(negedge clk);
    req0 = 1'b0;
    chk("wr_sel", 32'(sel), 32'h01);
    chk("wr_digit", 32'(digit), 32'hF);
    repeat (P - 1) @(negedge clk);
    chk("wr_dwell_digit", 32'(digit), 32'hF);
    @(negedge clk);
    chk("wr_next_digit", 32'(digit), 32'hE);
    chk("wr_next_idx", 32'(digit_idx), 32'd1);

    // Contention from reset: alternate 0,1,0,1,0,1
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    data0 = 32'h11111111;
    data1 = 32'h22222222;
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, 32'h11111111);
      push_exp(1'b1, 32'h22222222);
    end
    repeat (6) @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    chk("cont_last_word", disp_word, 32'h22222222);

    // Write arriving exactly at digit 7, last dwell cycle
    repeat (8 * P - 1) @(negedge clk);
    chk("d7_idx", 32'(digit_idx), 32'd7);
    req1 = 1'b1;
    data1 = 32'h00000305;
    push_exp(1'b1, 32'h00000305);
    @(negedge clk);
    req1 = 1'b0;
    chk("d7_no_frame_done", 32'(frame_done), 32'd0);
    chk("d7_restart_idx", 32'(digit_idx), 32'd0);
    chk("d7_restart_sel", 32'(sel), 32'h01);

    // Scan of 00000305: sel and digit per position (blanking if enabled)
    repeat (P / 2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] w305;
      w305 = 32'h00000305;
      chk("lzb_idx", 32'(digit_idx), 32'(k));
      chk("lzb_sel", 32'(sel), 32'(exp_sel(w305, k)));
      chk("lzb_digit", 32'(digit), 32'((w305 >> (4 * k)) & 32'hF));
      if (k < 7) repeat (P) @(negedge clk);
    end
    repeat (P / 2) @(negedge clk);
    chk("lzb_frame_done", 32'(frame_done), 32'd1);

    // Reset during a gnt1 cycle: grant is lost
    req1 = 1'b1;
    data1 = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    chk("rg_gnt1_before", 32'(gnt1), 32'd1);
    chk("rg_word_before", disp_word, 32'hDEADBEEF);
    #1;
    reset = 1'b1;
    req1 = 1'b0;
    #1;
    chk("rg_gnt1_drop", 32'(gnt1), 32'd0);
    chk("rg_word_clear", disp_word, 32'd0);
    chk("rg_sel", 32'(sel), 32'h01);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rg_no_regrant", disp_word, 32'd0);
    chk("rg_idx", 32'(digit_idx), 32'd0);

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_arbiter.md
# seg_scan_arbiter

Controller for the eight-digit seven-segment display peripheral. It owns the shared 32-bit display word and arbitrates round-robin between two write requesters (CPU store path and debug/switch path). It schedules the digit scan with a programmable per-digit dwell. It feeds the nibble to the segment decoder and drives the one-hot digit select.

## Interface
- PRESCALE, 16, clocks each digit is held before advancing; legal range >= 1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- req0  in  1  write request, requester 0 (CPU)
- data0  in  32  write data, requester 0
- gnt0  out  1  one-cycle grant/acknowledge, requester 0
- req1  in  1  write request, requester 1 (debug)
- data1  in  32  write data, requester 1
- gnt1  out  1  one-cycle grant/acknowledge, requester 1
- disp_word  out  32  current display word (readback)
- digit_idx  out  3  digit currently scanned
- digit  out  4  nibble disp_word[4*digit_idx+3 : 4*digit_idx]
- sel  out  8  one-hot digit select, bit digit_idx high
- frame_done  out  1  one-cycle pulse when digit 7 dwell completes

## Operation
- Registered state: disp_word, digit_idx, prescale counter pcnt (0..PRESCALE-1), last-grant pointer lg, gnt0, gnt1, frame_done.
- Eligibility: reqN eligible only when gntN is low, so a request still held during its grant cycle is not granted twice.
- Arbitration at each edge: one eligible requester wins. Two eligible: the winner is the requester other than lg. lg updates to the winner.
- On a win: disp_word <= winner's data; winner's gnt = 1 for the next cycle; digit_idx <= 0; pcnt <= 0 (scan restarts at digit 0).
- No win: pcnt increments. At pcnt == PRESCALE-1, pcnt <= 0 and digit_idx <= digit_idx+1, wrapping 7 -> 0. The 7 -> 0 wrap sets frame_done for one cycle.
- A write restarting the scan does not pulse frame_done, even when digit_idx is 7.
- digit and sel: combinational decode of registered digit_idx and disp_word.
- Requesters hold data stable while req is high until their gnt is seen. After gnt, dropping req ends the transaction; keeping req high is a new request one cycle later.

## Timing
- Reset values: disp_word 0, digit_idx 0, pcnt 0, sel 8'h01, digit 0, gnt0/gnt1 0, frame_done 0, lg = 1 (requester 0 wins first tie).
- Write latency: req sampled at edge E; gnt and new disp_word visible in cycle after E; digit/sel reflect the new word in that same cycle.
- Back-to-back contention: both requesters holding req are granted alternately, one grant per two cycles each. Grant cycles never overlap.
- Dwell: each digit is held exactly PRESCALE cycles. Full frame = 8*PRESCALE cycles.
- PRESCALE = 1: digit advances every cycle; frame_done every 8 cycles.
- Reset asserted mid-scan or mid-grant: all state returns to reset values immediately. A pending grant is lost and the requester must re-request.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking. For digit_idx k > 0, sel is forced 8'h00 when disp_word[31:4k] == 0. Digit 0 is never blanked. digit output is unaffected. Scan timing is unchanged.
- Undefined: sel is always one-hot of digit_idx.

## Test plan
- Reset, no requests, PRESCALE=16 -> sel steps 01,02,04,...,80 every 16 cycles. frame_done pulses once per 128 cycles. digit = 0 throughout.
- req0 with data0=32'h89ABCDEF for one cycle -> gnt0 high one cycle. disp_word=89ABCDEF and digit_idx=0 with digit=F. After 16 cycles, digit=E.
- req0 and req1 both held high, data 32'h11111111 / 32'h22222222, from reset -> grants go gnt0, gnt1, gnt0, gnt1... one per two cycles, never simultaneous. disp_word tracks the last granted requester.
- Write arriving while digit_idx=7 and pcnt=PRESCALE-1 -> digit_idx=0, pcnt=0, no frame_done pulse.
- SEG_LZB_EN with disp_word=32'h00000305 -> sel active for digits 0,1,2 only; sel=00 for digits 3..7. Without the macro, all 8 digits are selected.
- Reset pulse during a gnt1 cycle -> gnt1 drops at once. disp_word=0 and sel=01.
